// File: rtl/serial_pattern_pkg.sv
// Shared state encoding and default sizing for the serial pattern generator.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int unsigned DEF_MAX_LEN    = 8;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  localparam int unsigned REPS_W         = 4;

endpackage

// File: rtl/serial_pattern_generator_if.sv
// Request/status bundle between a pattern requester and the serial generator.
interface serial_pattern_generator_if #(
  parameter int unsigned MAX_LEN = serial_pattern_pkg::DEF_MAX_LEN
);
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned REPS_W = serial_pattern_pkg::REPS_W;

  logic                start;
  logic                abort;
  logic [MAX_LEN-1:0]  pattern;
  logic [LEN_W-1:0]    len;
  logic [REPS_W-1:0]   reps;
  logic                sout;
  logic                sout_valid;
  logic                busy;
  logic                done;

  modport master (
    output start, abort, pattern, len, reps,
    input  sout, sout_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, reps,
    output sout, sout_valid, busy, done
  );
endinterface

// File: rtl/pattern_shift_reg.sv
// Parallel-load MSB-first shifter; the loaded pattern is left-aligned so the
// register MSB is always the bit currently on the line.
module pattern_shift_reg #(
  parameter  int unsigned MAX_LEN = 8,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               bit_o,
  output logic               last_o
);

  logic [MAX_LEN-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  // Zeros fill in behind the last bit, so the line idles low without a mux.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      shreg_d = pattern_i << (LEN_W'(MAX_LEN) - len_i);
      cnt_d   = len_i;
    end else if (shift_i) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o  = shreg_q[MAX_LEN-1];
  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/serial_pattern_generator.sv
// Sends a latched pattern MSB-first reps+1 times with idle gaps between copies;
// FSM, gap and repeat counters live here, bit shifting in pattern_shift_reg.
module serial_pattern_generator
  import serial_pattern_pkg::*;
#(
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic                     clk,
  input logic                     rst,
  serial_pattern_generator_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e              state_q, state_d;
  logic [MAX_LEN-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [REPS_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sh_load, sh_shift, sh_clear, sh_bit, sh_last;
  logic [MAX_LEN-1:0]  sh_pat;
  logic [LEN_W-1:0]    sh_len;
  logic [LEN_W-1:0]    len_sat;

  assign len_sat = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

  // Next-state, latch and shifter control; outputs are registered from state_d.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    sh_load  = 1'b0;
    sh_clear = 1'b0;
    sh_pat   = pat_q;
    sh_len   = len_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_sat != '0) begin
            pat_d   = bus.pattern;
            len_d   = len_sat;
            rep_d   = bus.reps;
            sh_pat  = bus.pattern;
            sh_len  = len_sat;
            sh_load = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          if (rep_q == '0) begin
            state_d = ST_DONE;
          end else if (GAP_CYCLES == 0) begin
            rep_d   = rep_q - REPS_W'(1);
            sh_load = 1'b1;
          end else begin
            gap_d   = GAP_W'(GAP_CYCLES);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(1)) begin
          rep_d   = rep_q - REPS_W'(1);
          sh_load = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d  = ST_IDLE;
      sh_load  = 1'b0;
      sh_clear = 1'b1;
    end

    valid_d = (state_d == ST_SHIFT);
    busy_d  = (state_d == ST_SHIFT) || (state_d == ST_GAP);
    done_d  = (state_d == ST_DONE);
  end

  assign sh_shift = (state_q == ST_SHIFT) && !sh_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  pattern_shift_reg #(.MAX_LEN(MAX_LEN)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (sh_clear),
    .load_i    (sh_load),
    .shift_i   (sh_shift),
    .pattern_i (sh_pat),
    .len_i     (sh_len),
    .bit_o     (sh_bit),
    .last_o    (sh_last)
  );

  assign bus.sout       = sh_bit;
  assign bus.sout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/serial_pattern_generator.md
SERIAL_PATTERN_GENERATOR -- requirements
Module: serial_pattern_generator

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits.
REQ-002 Parameter GAP_CYCLES, default 2, SHALL set the idle-low cycles inserted between repeats; 0 SHALL be legal.
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL be the request to transmit, sampled only in IDLE.
REQ-006 abort  input  1  SHALL be the synchronous stop request, honoured in any non-IDLE state.
REQ-007 pattern  input  MAX_LEN  SHALL be the bits to send, latched on start acceptance.
REQ-008 len  input  $clog2(MAX_LEN+1)  SHALL be the number of bits to send (0..MAX_LEN), latched on start acceptance.
REQ-009 reps  input  4  SHALL be the extra repeat count; the pattern is sent reps+1 times.
REQ-010 sout  output  1  SHALL be the registered serial data bit.
REQ-011 sout_valid  output  1  SHALL be high exactly on cycles carrying a pattern bit.
REQ-012 busy  output  1  SHALL be high from the cycle after acceptance until completion or abort.
REQ-013 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL be Moore-type, with states IDLE, SHIFT, GAP and DONE; all outputs SHALL be registered.
REQ-015 IDLE: start=1 with len>=1 SHALL latch pattern/len/reps and enter SHIFT; start=1 with len=0 SHALL enter DONE without sending bits.
REQ-016 Latency: start sampled at edge T SHALL produce the first bit (pattern[len-1]) with sout_valid=1 during cycle T+1.
REQ-017 SHIFT SHALL send MSB-first, bits len-1 down to 0, one per cycle, with no bubbles.
REQ-018 After bit 0, the FSM SHALL go to GAP if the remaining repeats are >0 and GAP_CYCLES>0, go directly back to SHIFT if the remaining repeats are >0 and GAP_CYCLES=0, and go to DONE otherwise.
REQ-019 GAP SHALL hold sout=0 and sout_valid=0 with busy=1 for exactly GAP_CYCLES cycles, then return to SHIFT and decrement the repeat counter.
REQ-020 DONE SHALL last one cycle with done=1, busy=0, sout=0 and sout_valid=0, then return to IDLE.
REQ-021 In IDLE, sout, sout_valid, busy and done SHALL all be 0.
REQ-022 start asserted while busy or in DONE SHALL be ignored, with no queuing.
REQ-023 Changes to pattern, len or reps while busy SHALL NOT affect the transfer in progress.
REQ-024 abort=1 at any non-IDLE edge SHALL force IDLE on that edge: sout, sout_valid and busy go to 0 and done is NOT pulsed.
REQ-025 Simultaneous abort and start in IDLE SHALL be resolved in favour of start, since abort is ignored in IDLE.
REQ-026 len>MAX_LEN is illegal; the design SHALL saturate it to MAX_LEN.
REQ-027 reps=15 SHALL send 16 copies; the repeat counter SHALL NOT wrap.

Reset
REQ-028 rst=1 SHALL, on the next rising edge, force IDLE; clear sout, sout_valid, busy and done to 0; and clear all latched registers, overriding start and abort.
REQ-029 Reset asserted mid-transfer SHALL truncate the output immediately, with no done pulse.

Structure
REQ-030 The state encodings (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the default MAX_LEN and GAP_CYCLES values SHALL reside in a shared package, serial_pattern_pkg.
REQ-031 The parallel-load MSB-first shifter with its bit counter SHALL be a sub-module named pattern_shift_reg; the FSM, gap counter and repeat counter SHALL stay in the top level.

Verification
REQ-032 The bench SHALL cover: pattern=8'h05, len=3, reps=0, start at T -> sout 1,0,1 with valid=1 in cycles T+1..T+3; done=1 at T+4; busy=0 at T+4.
REQ-033 The bench SHALL cover: pattern=8'h05, len=3, reps=1, GAP_CYCLES=2 -> 1,0,1, then two cycles with valid=0, then 1,0,1, with done at T+9.
REQ-034 The bench SHALL cover: len=0 with start -> done=1 at T+1, with sout_valid never asserted.
REQ-035 The bench SHALL cover: pattern=8'hB4, len=8, abort at the third bit -> busy=0 and valid=0 on the next cycle, with done never asserted.
REQ-036 The bench SHALL cover: a second start pulse during a transfer, plus a pattern change mid-transfer -> the original bit stream is unchanged and exactly one done is produced.
REQ-037 The bench SHALL cover: rst=1 during GAP -> all outputs 0 after the edge, and a subsequent start behaves as in the first scenario.
